// File: rtl/terminal_input_pkg.sv
// Shared constants for the console I/O pages: page numbers, register offsets,
// STATUS bit positions and the register decode enum.
package terminal_input_pkg;

  localparam logic [23:0] TERM_OUT_PAGE = 24'h1;
  localparam logic [23:0] TERM_IN_PAGE  = 24'h2;
  localparam logic [7:0]  TERM_IN_DATA  = 8'h00;
  localparam logic [7:0]  TERM_IN_STAT  = 8'h04;

  localparam int STAT_AVAIL     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_UNDERRUN  = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DATA = 2'd1,
    REG_STAT = 2'd2
  } reg_sel_e;

  // A 256-deep FIFO reports 0 when full; software relies on the full bit.
  function automatic logic [7:0] count8(input logic [8:0] c);
    return c[7:0];
  endfunction

endpackage

// File: rtl/terminal_input_if.sv
// CPU load port and host byte stream of the console input block.
interface terminal_input_if;
  // Host stream: a byte is transferred on a rising edge where in_valid && in_ready;
  // the host holds in_valid/in_data stable until then, and in_ready never depends on in_valid.
  logic        re;
  logic [31:0] addr;
  logic        sel;
  logic [31:0] data_read;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        rx_avail;

  modport master (
    output re, addr, in_valid, in_data,
    input  sel, data_read, in_ready, rx_avail
  );

  modport slave (
    input  re, addr, in_valid, in_data,
    output sel, data_read, in_ready, rx_avail
  );
endinterface

// File: rtl/terminal_input_sync_fifo.sv
// First-word-fall-through synchronous FIFO; storage is deliberately not reset,
// only pointers and occupancy are.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/terminal_input.sv
// Memory-mapped console input: host bytes land in a FIFO, the CPU pops them
// through DATA and inspects occupancy/underrun through STATUS.
module terminal_input #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  terminal_input_if.slave  bus
);
  import terminal_input_pkg::*;

  reg_sel_e        reg_sel;
  logic            data_rd, stat_rd;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [ADDR_W:0] fifo_count;
  logic            underrun_q, underrun_d;
  logic [31:0]     status_w;

  assign bus.sel = (bus.addr[31:8] == TERM_IN_PAGE);

  always_comb begin
    reg_sel = REG_NONE;
    if (bus.sel) begin
      case (bus.addr[7:0])
        TERM_IN_DATA: reg_sel = REG_DATA;
        TERM_IN_STAT: reg_sel = REG_STAT;
        default:      reg_sel = REG_NONE;
      endcase
    end
  end

  assign data_rd = bus.re && (reg_sel == REG_DATA);
  assign stat_rd = bus.re && (reg_sel == REG_STAT);

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (bus.in_valid),
    .pop   (data_rd),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.in_ready = !fifo_full;
  assign bus.rx_avail = !fifo_empty;

  // DATA and STATUS are distinct offsets, so set and clear never collide.
  always_comb begin
    underrun_d = underrun_q;
    if (data_rd && fifo_empty) underrun_d = 1'b1;
    else if (stat_rd)          underrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) underrun_q <= 1'b0;
    else          underrun_q <= underrun_d;
  end

  always_comb begin
    status_w = '0;
    status_w[STAT_AVAIL]    = !fifo_empty;
    status_w[STAT_FULL]     = fifo_full;
    status_w[STAT_UNDERRUN] = underrun_q;
    status_w[STAT_COUNT_LSB +: 8] = count8(9'(fifo_count));
  end

  always_comb begin
    bus.data_read = '0;
    case (reg_sel)
      REG_DATA: bus.data_read = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
      REG_STAT: bus.data_read = status_w;
      default:  bus.data_read = '0;
    endcase
  end

endmodule

// File: tb/tb_terminal_input.sv
// Bench for terminal_input: directed and random traffic, expected read data
// queued from a byte-queue reference model and checked by a negedge monitor.
module tb_terminal_input;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DATA  = 32'h0000_0200;
  localparam logic [31:0] A_STAT  = 32'h0000_0204;
  localparam logic [31:0] A_OTHER = 32'h0000_0208;
  localparam logic [31:0] A_OUTW  = 32'h0000_0104;
  localparam logic [31:0] A_OUTP  = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  terminal_input_if bif();

  terminal_input #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  ref_q[$];
  bit          ref_underrun = 1'b0;
  bit          pend = 1'b0;
  logic [7:0]  pend_data = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Register contents computed directly from the queue of buffered bytes.
  function automatic logic [31:0] model_read(input logic [31:0] a);
    int n;
    n = ref_q.size();
    if (a[31:8] != 24'h2) return 32'h0;
    if (a[7:0] == 8'h00) return (n > 0) ? {24'h0, ref_q[0]} : 32'h0;
    if (a[7:0] == 8'h04)
      return 32'((n % 256) * 256 + (ref_underrun ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n > 0 ? 1 : 0));
    return 32'h0;
  endfunction

  // One clock cycle of stimulus; returns whether the host byte was accepted.
  task automatic step(input bit do_re, input logic [31:0] a, input bit do_push,
                      input logic [7:0] b, output bit accepted);
    bit in_rst;
    bif.re       = do_re;
    bif.addr     = a;
    bif.in_valid = do_push;
    bif.in_data  = b;
    if (do_re) exp_q.push_back(model_read(a));
    in_rst   = !reset_n;
    accepted = do_push && !in_rst && (ref_q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (!in_rst) begin
      if (do_re && a == A_DATA) begin
        if (ref_q.size() > 0) void'(ref_q.pop_front());
        else ref_underrun = 1'b1;
      end
      if (do_re && a == A_STAT) ref_underrun = 1'b0;
      if (accepted) ref_q.push_back(b);
    end
    bif.re       = 1'b0;
    bif.in_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bit acc;
    step(1'b1, a, 1'b0, 8'h00, acc);
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      step(1'b0, A_DATA, 1'b1, b, acc);
      tries++;
    end
    if (!acc) chk("push_timeout", 32'(tries), 32'h0);
  endtask

  // Random cycle: the host keeps a pending byte asserted until it is taken.
  task automatic rand_op();
    bit          do_re, acc;
    logic [31:0] a;
    int          pick;
    do_re = ($urandom_range(0, 1) == 1);
    pick  = $urandom_range(0, 9);
    a = (pick < 5) ? A_DATA : (pick < 7) ? A_STAT : (pick == 7) ? A_OTHER :
        (pick == 8) ? A_OUTW : A_OUTP;
    if (!pend && $urandom_range(0, 9) < 6) begin
      pend = 1'b1;
      pend_data = 8'($urandom_range(0, 255));
    end
    step(do_re, a, pend, pend_data, acc);
    if (acc) pend = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("in_ready", {31'h0, bif.in_ready}, {31'h0, ref_q.size() < DEPTH});
    chk("rx_avail", {31'h0, bif.rx_avail}, {31'h0, ref_q.size() > 0});
    if (bif.re) begin
      chk("sel", {31'h0, bif.sel}, {31'h0, bif.addr[31:8] == 24'h2});
      if (exp_q.size() == 0) chk("unexpected_read", bif.data_read, 32'hx);
      else chk("data_read", bif.data_read, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    bif.re = 1'b0;
    bif.addr = 32'h0;
    bif.in_valid = 1'b0;
    bif.in_data = 8'h0;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    rd(A_STAT);

    // Three bytes in, STATUS, then in-order reads.
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    rd(A_STAT);
    repeat (3) rd(A_DATA);
    rd(A_STAT);

    // Fill, hold a 17th byte across a pop, then drain.
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
    rd(A_STAT);
    step(1'b1, A_DATA, 1'b1, 8'h10, acc);
    chk("held_while_full", {31'h0, acc}, 32'h0);
    step(1'b0, A_DATA, 1'b1, 8'h10, acc);
    chk("accepted_after_pop", {31'h0, acc}, 32'h1);
    rd(A_STAT);
    repeat (DEPTH) rd(A_DATA);

    // Underrun and its clear-on-read.
    rd(A_DATA);
    rd(A_STAT);
    rd(A_STAT);

    // Simultaneous push and pop, then mixed ops wrapping the pointers.
    push_byte(8'hA1); push_byte(8'hA2);
    step(1'b1, A_DATA, 1'b1, 8'h55, acc);
    rd(A_STAT);
    repeat (40) rand_op();
    while (pend) rand_op();
    while (ref_q.size() > 0) rd(A_DATA);
    rd(A_STAT);

    // Empty plus push plus DATA read: read sees 0, byte is read next.
    step(1'b1, A_DATA, 1'b1, 8'h77, acc);
    rd(A_DATA);
    rd(A_STAT);

    repeat (300) rand_op();
    while (pend) rand_op();

    // Reset mid-stream with five bytes buffered.
    while (ref_q.size() > 0) rd(A_DATA);
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    reset_n = 1'b0;
    ref_q.delete();
    ref_underrun = 1'b0;
    #1;
    chk("rst_in_ready", {31'h0, bif.in_ready}, 32'h1);
    chk("rst_rx_avail", {31'h0, bif.rx_avail}, 32'h0);
    rd(A_STAT);
    reset_n = 1'b1;
    rd(A_DATA);
    rd(A_STAT);

    // Outside-window read returns 0 and pops nothing.
    push_byte(8'h99);
    rd(A_OUTW);
    rd(A_STAT);
    rd(A_DATA);
    rd(A_STAT);

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
